// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides of the serial link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Total bits on the wire for one frame, start bit included.
  function automatic int frame_bits(input bit parity_en);
    return 1 + DATA_BITS + (parity_en ? 1 : 0) + STOP_BITS;
  endfunction

endpackage

// File: rtl/transmit_baud_timer.sv
// Reloadable bit-period down-counter: load restarts at CYCLES-1, tick while the count sits at 0.
module baud_timer #(
  parameter int CYCLES = 1250
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic tick_o,
  output logic last_o
);

  localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= RELOAD;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tick_o = (count_q == '0);
  // One clock before terminal count; lets the FSM register rdy for the final stop clock.
  assign last_o = (count_q == W'(1));

endmodule

// File: rtl/transmit.sv
// UART transmitter, 8N1 frames on txd from a stb/rdy byte source.
// Define TRANSMIT_PARITY_EN to insert an even-parity bit between data and stop (8E1).
//
// state  | meaning
// IDLE   | line at mark, rdy high, waiting for a byte
// START  | start bit (txd=0)
// DATA   | data bits LSB first, bit_idx 0..7
// PARITY | even parity of the latched byte (TRANSMIT_PARITY_EN only)
// STOP   | stop bit (txd=1); rdy high in its final clock for gapless back-to-back
module transmit
  import uart_pkg::*;
#(
  parameter real BAUDRATE  = 96e2,
  parameter real FREQUENCY = 12e6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stb,
  input  logic [7:0] dat,
  output logic       rdy,
  output logic       txd
);

  localparam int CYCLES = $rtoi(FREQUENCY / BAUDRATE);

  if (CYCLES < 2) begin : g_cycles_check
    $error("transmit: FREQUENCY/BAUDRATE must give at least 2 clocks per bit");
  end

  state_t     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_idx_q;
  logic       txd_q;
  logic       rdy_q;
`ifdef TRANSMIT_PARITY_EN
  logic       parity_q;
`endif

  logic tick;
  logic last;
  logic accept;
  logic load;

  assign accept = stb && rdy_q;
  assign load   = accept ||
                  (tick && (state_q == START || state_q == DATA || state_q == PARITY));

  baud_timer #(
    .CYCLES (CYCLES)
  ) u_baud_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .tick_o (tick),
    .last_o (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      rdy_q     <= 1'b0;
`ifdef TRANSMIT_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          rdy_q <= 1'b1;
          if (accept) begin
            state_q  <= START;
            txd_q    <= 1'b0;
            rdy_q    <= 1'b0;
            shift_q  <= dat;
`ifdef TRANSMIT_PARITY_EN
            parity_q <= ^dat;
`endif
          end
        end

        START: begin
          if (tick) begin
            state_q   <= DATA;
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef TRANSMIT_PARITY_EN
              state_q <= PARITY;
              txd_q   <= parity_q;
`else
              state_q <= STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end

`ifdef TRANSMIT_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_q <= STOP;
            txd_q   <= 1'b1;
          end
        end
`endif

        STOP: begin
          if (tick) begin
            if (accept) begin
              state_q  <= START;
              txd_q    <= 1'b0;
              rdy_q    <= 1'b0;
              shift_q  <= dat;
`ifdef TRANSMIT_PARITY_EN
              parity_q <= ^dat;
`endif
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
              rdy_q   <= 1'b1;
            end
          end else begin
            rdy_q <= last;
          end
        end

        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign txd = txd_q;
  assign rdy = rdy_q;

endmodule
